// File: rtl/pong_match_sequencer.sv
// Pong match sequencer: IDLE/SERVE/PLAY/POINT/OVER control with scoring.
// Ports: game_clk, reset (sync, active-high), frame_tick, start, lossA,
//   lossB in; ball_reset, motion_en, serve_dir, scoreA, scoreB,
//   game_over, winner, state out. All outputs come from registers.
module pong_match_sequencer #(
  parameter int WIN_SCORE   = 5,
  parameter int SERVE_DELAY = 60,
  parameter int POINT_HOLD  = 30
) (
  input  logic       game_clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       lossA,
  input  logic       lossB,
  output logic       ball_reset,
  output logic       motion_en,
  output logic       serve_dir,
  output logic [2:0] scoreA,
  output logic [2:0] scoreB,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_POINT = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  localparam logic [2:0] WIN  = 3'(WIN_SCORE);
  localparam logic [7:0] SDLY = 8'(SERVE_DELAY);
  localparam logic [7:0] PHLD = 8'(POINT_HOLD);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] scoreA_q, scoreA_d;
  logic [2:0] scoreB_q, scoreB_d;
  logic       dir_q, dir_d;
  logic       winner_q, winner_d;
  logic       start_q;

  logic       start_edge;
  logic       serve_done;
  logic       hold_done;
  logic       match_won;
  logic [7:0] cnt_inc;

  assign start_edge = start & ~start_q;
  assign cnt_inc    = cnt_q + 8'd1;
  // The tick that would make the counter reach its limit ends the phase.
  assign serve_done = frame_tick && (cnt_inc == SDLY);
  assign hold_done  = frame_tick && (cnt_inc == PHLD);
  assign match_won  = (scoreA_q == WIN) || (scoreB_q == WIN);

  // State register (plus datapath registers).
  always_ff @(posedge game_clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      scoreA_q <= 3'd0;
      scoreB_q <= 3'd0;
      dir_q    <= 1'b0;
      winner_q <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      scoreA_q <= scoreA_d;
      scoreB_q <= scoreB_d;
      dir_q    <= dir_d;
      winner_q <= winner_d;
      start_q  <= start;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_edge) state_d = S_SERVE;
      S_SERVE: if (serve_done) state_d = S_PLAY;
      S_PLAY:  if (lossA || lossB) state_d = S_POINT;
      S_POINT: begin
        if (hold_done) state_d = match_won ? S_OVER : S_SERVE;
      end
      S_OVER:  if (start_edge) state_d = S_SERVE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: frame counter, scores, serve direction, winner.
  always_comb begin
    cnt_d    = cnt_q;
    scoreA_d = scoreA_q;
    scoreB_d = scoreB_q;
    dir_d    = dir_q;
    winner_d = winner_q;

    if (state_d != state_q) cnt_d = 8'd0;
    else if (frame_tick)    cnt_d = cnt_inc;

    if ((state_q == S_IDLE || state_q == S_OVER) && start_edge) begin
      scoreA_d = 3'd0;
      scoreB_d = 3'd0;
    end

    // A double miss is a dead ball: no score, direction kept.
    if (state_q == S_PLAY) begin
      unique case (1'b1)
        lossA && !lossB: begin
          if (scoreB_q != WIN) scoreB_d = scoreB_q + 3'd1;
          dir_d = 1'b0;
        end
        lossB && !lossA: begin
          if (scoreA_q != WIN) scoreA_d = scoreA_q + 3'd1;
          dir_d = 1'b1;
        end
        default: ;
      endcase
    end

    if (state_q == S_POINT && state_d == S_OVER)
      winner_d = (scoreA_q == WIN) ? 1'b0 : 1'b1;
  end

  // Output decode from registered state only.
  always_comb begin
    ball_reset = 1'b1;
    motion_en  = 1'b0;
    game_over  = 1'b0;
    unique case (state_q)
      S_IDLE:  ;
      S_SERVE: ;
      S_PLAY: begin
        ball_reset = 1'b0;
        motion_en  = 1'b1;
      end
      S_POINT: ball_reset = 1'b0;
      S_OVER:  game_over = 1'b1;
      default: ;
    endcase
  end

  assign serve_dir = dir_q;
  assign scoreA    = scoreA_q;
  assign scoreB    = scoreB_q;
  assign winner    = winner_q;
  assign state     = state_q;

endmodule

// File: doc/pong_match_sequencer.md
PONG_MATCH_SEQUENCER -- requirements
Module: pong_match_sequencer

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 5, points needed to win a match (legal range 1..7).
REQ-002 SHALL have parameter SERVE_DELAY, default 60, frame_tick pulses spent in SERVE before release (legal range 1..255).
REQ-003 SHALL have parameter POINT_HOLD, default 30, frame_tick pulses spent frozen in POINT (legal range 1..255).
REQ-004 SHALL have port game_clk, input, 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 SHALL have port frame_tick, input, 1, one-cycle pulse per video frame; the only timing base.
REQ-007 SHALL have port start, input, 1, level-sensitive start/restart button, already debounced.
REQ-008 SHALL have port lossA, input, 1, ball passed player A's wall (A missed).
REQ-009 SHALL have port lossB, input, 1, ball passed player B's wall (B missed).
REQ-010 SHALL have port ball_reset, output, 1, holds ball and paddles at serve position while high.
REQ-011 SHALL have port motion_en, output, 1, enables ball/paddle movement while high.
REQ-012 SHALL have port serve_dir, output, 1, initial ball x-direction (0 toward A, 1 toward B).
REQ-013 SHALL have ports scoreA and scoreB, output, 3 each, match points for each player.
REQ-014 SHALL have port game_over, output, 1, high while in OVER.
REQ-015 SHALL have port winner, output, 1, 0 = A won, 1 = B won; valid only while game_over is high.
REQ-016 SHALL have port state, output, 3, encoded current state for display/debug.

Function
REQ-017 SHALL implement states IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4; codes 5..7 SHALL transition to IDLE on the next clock.
REQ-018 SHALL detect a start press as a rising edge against a registered copy of start; holding start high SHALL NOT re-trigger.
REQ-019 IDLE: ball_reset=1, motion_en=0; on a start edge, go to SERVE with scores cleared.
REQ-020 SHALL keep one 8-bit frame counter, cleared on every state entry and incremented only on cycles with frame_tick=1.
REQ-021 SERVE: ball_reset=1, motion_en=0; on the cycle the counter would reach SERVE_DELAY, go to PLAY.
REQ-022 PLAY: ball_reset=0, motion_en=1; sample lossA/lossB every clock.
REQ-023 PLAY with lossA=1 and lossB=0: scoreB += 1, serve_dir = 0 (next serve goes toward the loser), go to POINT, all in the same clock.
REQ-024 PLAY with lossB=1 and lossA=0: scoreA += 1, serve_dir = 1, go to POINT.
REQ-025 PLAY with lossA=1 and lossB=1 on the same cycle: no score change, serve_dir unchanged, go to POINT.
REQ-026 lossA/lossB SHALL be ignored in every state except PLAY.
REQ-027 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-028 POINT: ball_reset=0, motion_en=0 (field frozen for display); after POINT_HOLD frame_ticks, go to OVER if either score equals WIN_SCORE, else go to SERVE.
REQ-029 On entry to OVER, winner SHALL be latched: 0 if scoreA==WIN_SCORE, else 1.
REQ-030 OVER: game_over=1, ball_reset=1, motion_en=0, scores held; on a start edge, clear both scores and go to SERVE.
REQ-031 All outputs SHALL be registered, or decoded only from registered state; no input-to-output combinational path.
REQ-032 A start edge in SERVE, PLAY or POINT SHALL be ignored.

Reset
REQ-033 reset=1 at a clock edge SHALL force, from any state including mid-SERVE, mid-PLAY or mid-POINT: state=IDLE, counter=0, scoreA=scoreB=0, serve_dir=0, winner=0, game_over=0, ball_reset=1, motion_en=0, start-edge register=0.
REQ-034 reset SHALL take priority over every other input on the same cycle.

Verification
REQ-035 Reset, then a start pulse, then 60 frame_ticks -> state goes 0->1->2; motion_en rises exactly on the clock of the 60th tick.
REQ-036 In PLAY, a one-cycle lossB -> next cycle scoreA=1, serve_dir=1, state=3; after 30 ticks, state=1.
REQ-037 In PLAY, lossA and lossB on the same cycle -> scores unchanged, state=3, serve_dir unchanged.
REQ-038 Drive 5 lossA points -> scoreB=5; after POINT_HOLD, state=4, game_over=1, winner=1; a further lossA leaves scoreB=5.
REQ-039 In OVER, hold start high for 10 cycles -> one restart only: scores 0, state=1; a start press in PLAY -> no effect.
REQ-040 Assert reset mid-POINT with scoreA=3 -> next cycle every output matches REQ-033.
